// File: rtl/btn_event_ctrl.sv
// Key debouncer and event queue: debounces the 20-bit scanner vector on periodic
// sample ticks and queues one press/release code per changed key into a small FIFO.
module btn_event_ctrl #(
   parameter int CLK_FREQ      = 100,
   parameter int SAMPLE_CYCLES = 100000,
   parameter int DEB_SAMPLES   = 3,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [19:0]                 keys,
   output logic [19:0]                 key_state,
   output logic                        evt_valid,
   output logic [5:0]                  evt_code,
   input  logic                        evt_ready,
   output logic [$clog2(FIFO_DEPTH):0] evt_count,
   output logic                        overflow,
   input  logic                        clr_ovf,
   output logic                        busy
);

   localparam int              NK     = 20;
   localparam int              TW     = $clog2(SAMPLE_CYCLES);
   localparam int              PW     = $clog2(FIFO_DEPTH);
   localparam logic [2:0]      DEB    = 3'(DEB_SAMPLES);
   localparam logic [TW-1:0]   T_LAST = TW'(SAMPLE_CYCLES - 1);
   localparam logic [PW:0]     FULL   = (PW + 1)'(FIFO_DEPTH);
   localparam logic [4:0]      LAST_K = 5'(NK - 1);

   if (CLK_FREQ < 1 || SAMPLE_CYCLES < 32 || DEB_SAMPLES < 1 || DEB_SAMPLES > 7 ||
       FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("btn_event_ctrl: illegal parameter set");
   end

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state, state_next;
   logic [TW-1:0]   tmr;
   logic            tick;
   logic [2:0]      deb_cnt [NK];
   logic [NK-1:0]   flip;
   logic [NK-1:0]   pending;
   logic [NK-1:0]   clr_mask;
   logic [4:0]      idx;
   logic            push_req, push_ok, pop, full, drop;
   logic [5:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;

   assign tick = (tmr == T_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmr <= '0;
      else     tmr <= tick ? '0 : tmr + 1'b1;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      flip = '0;
      for (int i = 0; i < NK; i++)
         flip[i] = tick && (keys[i] != key_state[i]) && (deb_cnt[i] + 3'd1 == DEB);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_state <= '0;
         for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
      end else if (tick) begin
         key_state <= key_state ^ flip;
         for (int i = 0; i < NK; i++) begin
            if (keys[i] == key_state[i] || flip[i]) deb_cnt[i] <= '0;
            else                                    deb_cnt[i] <= deb_cnt[i] + 3'd1;
         end
      end
   end

   // A new flip wins over the scan clearing the same key; it is reported next pass.
   assign push_req = (state == SCAN) && pending[idx];
   assign clr_mask = push_req ? (NK'(1) << idx) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clr_mask) | flip;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|pending)       state_next = SCAN;
         SCAN:    if (idx == LAST_K)  state_next = IDLE;
         default:                     state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SCAN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                idx <= '0;
      else if (state == SCAN && idx != LAST_K) idx <= idx + 5'd1;
      else                                    idx <= '0;
   end

   assign evt_valid = (evt_count != '0);
   assign full      = (evt_count == FULL);
   assign pop       = evt_valid && evt_ready;
   assign push_ok   = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;

   // NOTE: the storage array carries no reset; evt_code is masked while empty instead.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {~key_state[idx], idx};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   evt_count <= evt_count + 1'b1;
            2'b01:   evt_count <= evt_count - 1'b1;
            default: evt_count <= evt_count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   assign evt_code = evt_valid ? mem[rd_ptr] : 6'd0;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: expected event codes are queued when keys are
// driven and compared as the FIFO presents them.
module tb_btn_event_ctrl;

   localparam int SC = 40;
   localparam int DS = 3;
   localparam int FD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] keys;
   logic [19:0] key_state;
   logic        evt_valid;
   logic [5:0]  evt_code;
   logic        evt_ready;
   logic [2:0]  evt_count;
   logic        overflow;
   logic        clr_ovf;
   logic        busy;

   int         tests = 0;
   int         fails = 0;
   int         t     = 0;
   int         e     = 0;
   logic [5:0] sb[$];

   btn_event_ctrl #(
      .CLK_FREQ(100), .SAMPLE_CYCLES(SC), .DEB_SAMPLES(DS), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .keys(keys), .key_state(key_state),
      .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
      .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
         t += n;
      end
   endtask

   task automatic goto(input int edge_no);
      step(edge_no - t);
   endtask

   function automatic int next_tick();
      return ((t / SC) + 1) * SC;
   endfunction

   // Wait (bounded) for the head, compare it with the scoreboard, then pop it.
   task automatic pop_check(input string tag);
      int         w;
      logic [6:0] exp;
      w = 0;
      while (!evt_valid && w < 400) begin
         step(1);
         w++;
      end
      check({tag, "_valid"}, evt_valid, 1);
      exp = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 7'h7f;
      check({tag, "_code"}, {1'b0, evt_code}, exp);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_key_state"}, key_state, 0);
      check({tag, "_evt_valid"}, evt_valid, 0);
      check({tag, "_evt_code"},  evt_code,  0);
      check({tag, "_evt_count"}, evt_count, 0);
      check({tag, "_overflow"},  overflow,  0);
      check({tag, "_busy"},      busy,      0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; keys = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      t = 0;

      // Debounced press of key 3, with exact flip and push latency.
      keys = 20'h00008;
      sb.push_back(6'h03);
      goto(119); check("press_before_3rd_tick", key_state, 20'h0);
      goto(120); check("press_on_3rd_tick", key_state, 20'h00008);
      check("busy_not_yet", busy, 0);
      goto(121); check("busy_scan", busy, 1);
      goto(124); check("valid_before_push", evt_valid, 0);
      goto(125); check("valid_after_push", evt_valid, 1);
      check("count_one", evt_count, 1);
      pop_check("press_k3");
      check("count_after_pop", evt_count, 0);

      // Release of key 3.
      keys = 20'h0;
      sb.push_back(6'h23);
      pop_check("release_k3");
      check("released_state", key_state, 20'h0);

      // Bounce: alternate samples never reach the threshold.
      for (int k = 0; k < 10; k++) begin
         keys = (k % 2 == 0) ? 20'h00008 : 20'h0;
         goto(next_tick());
      end
      keys = 20'h0;
      step(30);
      check("bounce_state", key_state, 20'h0);
      check("bounce_valid", evt_valid, 0);
      check("bounce_count", evt_count, 0);

      // Two keys in one pass arrive in ascending index order.
      keys = 20'h80001;
      sb.push_back(6'h00); sb.push_back(6'h13);
      pop_check("multi_press_k0");
      pop_check("multi_press_k19");
      keys = 20'h0;
      sb.push_back(6'h20); sb.push_back(6'h33);
      pop_check("multi_rel_k0");
      pop_check("multi_rel_k19");
      check("multi_state", key_state, 20'h0);

      // Overflow: five presses (1,2,4,7,9) into a four-deep FIFO, no consumer.
      keys = 20'h00296;
      e = next_tick() + 2 * SC;
      sb.push_back(6'h01); sb.push_back(6'h02); sb.push_back(6'h04); sb.push_back(6'h07);
      goto(e + 10);
      check("ovf_full_count", evt_count, 4);
      check("ovf_not_yet", overflow, 0);
      goto(e + 11);
      check("ovf_count", evt_count, 4);
      check("ovf_set", overflow, 1);
      check("ovf_head", evt_code, 6'h01);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      for (int k = 0; k < 4; k++) pop_check("ovf_drain");
      step(50);
      check("ovf_no_replay", evt_valid, 0);

      // Full FIFO with a pop in the same cycle as the fifth push.
      keys = 20'h0;
      e = next_tick() + 2 * SC;
      sb.push_back(6'h21); sb.push_back(6'h22); sb.push_back(6'h24);
      sb.push_back(6'h27); sb.push_back(6'h29);
      goto(e + 10);
      check("fullpop_full", evt_count, 4);
      check("fullpop_head", evt_code, sb.pop_front());
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      check("fullpop_count", evt_count, 4);
      check("fullpop_no_ovf", overflow, 0);
      for (int k = 0; k < 4; k++) pop_check("fullpop_drain");
      check("fullpop_empty", evt_valid, 0);

      // Asynchronous reset in the middle of a scan, key held through it.
      keys = 20'h80000;
      e = next_tick() + 2 * SC;
      sb.push_back(6'h13);
      goto(e + 5);
      check("midscan_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      sb.delete();
      sb.push_back(6'h13);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      t = 0;
      goto(119); check("rearm_before", key_state, 20'h0);
      goto(120); check("rearm_state", key_state, 20'h80000);
      goto(140); check("rearm_valid_before", evt_valid, 0);
      goto(141); check("rearm_valid", evt_valid, 1);
      pop_check("rearm_k19");
      check("final_empty", evt_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
